// File: rtl/alu_pkg.sv
// Shared ALU definitions: pack modes, compare ops and lane widths
// for the subtract/compare pipeline stage.
package alu_pkg;

  typedef enum logic [1:0] {
    WORD = 2'b00,
    HALF = 2'b01,
    BYTE = 2'b10
  } pack_mode_e;

  typedef enum logic [1:0] {
    OP_SUB  = 2'b00,
    OP_SEQ  = 2'b01,
    OP_SNE  = 2'b10,
    OP_RSVD = 2'b11
  } cmp_op_e;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  function automatic logic [WORD_W-1:0] expand4(
    input logic [3:0] m
  );
    return {{BYTE_W{m[3]}}, {BYTE_W{m[2]}},
            {BYTE_W{m[1]}}, {BYTE_W{m[0]}}};
  endfunction

endpackage

// File: rtl/lane_cmp_mask.sv
// Combinational packed SEQ/SNE mask former; SUB and the
// reserved op pass the difference through unchanged.
module lane_cmp_mask
  import alu_pkg::*;
(
  input  logic [WORD_W-1:0] diff,
  input  logic [1:0]        pack_mode,
  input  logic [1:0]        op,
  output logic [WORD_W-1:0] result
);

  logic [3:0] zero;
  logic       mode_ok;
  logic       z_word;
  logic [1:0] z_half;
  logic [3:0] z_byte;

  assign z_word = (diff == '0);
  assign z_half = {diff[31:16] == '0, diff[15:0] == '0};
  assign z_byte = {diff[31:24] == '0, diff[23:16] == '0,
                   diff[15:8] == '0, diff[7:0] == '0};

  // zero flags are tracked per byte lane so one expander serves all modes
  always_comb begin
    zero    = '0;
    mode_ok = 1'b1;
    unique case (pack_mode)
      WORD:    zero = {4{z_word}};
      HALF:    zero = {{2{z_half[1]}}, {2{z_half[0]}}};
      BYTE:    zero = z_byte;
      default: mode_ok = 1'b0;
    endcase
  end

  always_comb begin
    result = diff;
    unique case (1'b1)
      (!mode_ok):               result = '0;
      (mode_ok && op == OP_SEQ): result = expand4(zero);
      (mode_ok && op == OP_SNE): result = expand4(~zero);
      default:                  result = diff;
    endcase
  end

endmodule

// File: rtl/sub_cmp_stage.sv
// Subtract/compare result stage with 2-entry skid buffer.
// Optional perf counters: define SUB_CMP_STAGE_PERF_EN.
module sub_cmp_stage
  import alu_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_diff,
  input  logic [1:0]       in_pack_mode,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
`ifdef SUB_CMP_STAGE_PERF_EN
  output logic [CNT_W-1:0] perf_xfer_cnt,
  output logic [CNT_W-1:0] perf_stall_cnt,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  logic             main_valid;
  logic             skid_valid;
  logic             rdy_q;
  logic [31:0]      main_res;
  logic [31:0]      skid_res;
  logic [31:0]      new_res;
  logic [TAG_W-1:0] main_tag;
  logic [TAG_W-1:0] skid_tag;
  logic             in_xfer;
  logic             main_free;

  lane_cmp_mask u_mask (
    .diff      (in_diff),
    .pack_mode (in_pack_mode),
    .op        (in_op),
    .result    (new_res)
  );

  assign in_xfer   = in_valid && rdy_q;
  assign main_free = !main_valid || out_ready;

  assign in_ready   = rdy_q;
  assign out_valid  = main_valid;
  assign out_result = main_res;
  assign out_tag    = main_tag;

  // skid only fills while main is stalled, and drains before new input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_res   <= '0;
      main_tag   <= '0;
      skid_valid <= 1'b0;
      skid_res   <= '0;
      skid_tag   <= '0;
      rdy_q      <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_res   <= skid_res;
        main_tag   <= skid_tag;
        skid_valid <= 1'b0;
        rdy_q      <= 1'b1;
      end else begin
        main_valid <= in_xfer;
        if (in_xfer) begin
          main_res <= new_res;
          main_tag <= in_tag;
        end
      end
    end else if (in_xfer) begin
      skid_valid <= 1'b1;
      skid_res   <= new_res;
      skid_tag   <= in_tag;
      rdy_q      <= 1'b0;
    end
  end

`ifdef SUB_CMP_STAGE_PERF_EN
  logic out_xfer;
  logic stall;

  assign out_xfer = main_valid && out_ready;
  assign stall    = main_valid && !out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_xfer_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (out_xfer) perf_xfer_cnt <= perf_xfer_cnt + 1'b1;
      if (stall) perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_cmp_stage.sv
// Directed self-checking bench for sub_cmp_stage.
// Perf checks build only with SUB_CMP_STAGE_PERF_EN.
module tb_sub_cmp_stage;

  localparam int TAG_W = 5;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_diff;
  logic [1:0]       in_pack_mode;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
`ifdef SUB_CMP_STAGE_PERF_EN
  logic [CNT_W-1:0] perf_xfer_cnt;
  logic [CNT_W-1:0] perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sub_cmp_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_diff      (in_diff),
    .in_pack_mode (in_pack_mode),
    .in_op        (in_op),
    .in_tag       (in_tag),
`ifdef SUB_CMP_STAGE_PERF_EN
    .perf_xfer_cnt  (perf_xfer_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_tag      (out_tag)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m,
                      input logic [1:0] o, input logic [TAG_W-1:0] t);
    in_valid     = 1'b1;
    in_diff      = d;
    in_pack_mode = m;
    in_op        = o;
    in_tag       = t;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b1; in_valid = 1'b1;
    in_diff = 32'hDEAD_BEEF; in_pack_mode = 2'b00;
    in_op = 2'b00; in_tag = 5'd9; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
    n_checks++;
    if (out_result !== 32'h0)
      $display("FAIL reset_out_result got %h want 0", out_result);
    else n_pass++;
    n_checks++;
    if (out_tag !== '0)
      $display("FAIL reset_out_tag got %h want 0", out_tag);
    else n_pass++;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sub_word;
    out_ready = 1'b1;
    send(32'h0000_0005, 2'b00, 2'b00, 5'd3);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_0005 ||
        out_tag !== 5'd3)
      $display("FAIL sub_word got v=%b r=%h t=%0d want v=1 r=00000005 t=3",
               out_valid, out_result, out_tag);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL sub_word_drain got %b want 0", out_valid);
    else n_pass++;
  endtask

  task automatic test_masks;
    out_ready = 1'b1;
    send(32'h00FF_0000, 2'b10, 2'b01, 5'd7);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hFF00_FFFF ||
        out_tag !== 5'd7)
      $display("FAIL seq_byte got v=%b r=%h t=%0d want v=1 r=ff00ffff t=7",
               out_valid, out_result, out_tag);
    else n_pass++;
    send(32'h0000_1234, 2'b01, 2'b10, 5'd9);
    n_checks++;
    if (out_result !== 32'h0000_FFFF || out_tag !== 5'd9)
      $display("FAIL sne_half got r=%h t=%0d want r=0000ffff t=9",
               out_result, out_tag);
    else n_pass++;
    send(32'h0000_0000, 2'b00, 2'b01, 5'd2);
    n_checks++;
    if (out_result !== 32'hFFFF_FFFF)
      $display("FAIL seq_word got %h want ffffffff", out_result);
    else n_pass++;
    send(32'hA5A5_0001, 2'b00, 2'b11, 5'd4);
    n_checks++;
    if (out_result !== 32'hA5A5_0001 || out_tag !== 5'd4)
      $display("FAIL rsvd_op got r=%h t=%0d want r=a5a50001 t=4",
               out_result, out_tag);
    else n_pass++;
    tick();
  endtask

  task automatic test_invalid_mode;
    out_ready = 1'b1;
    send(32'h0000_0000, 2'b11, 2'b01, 5'd21);
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0 || out_tag !== 5'd21)
      $display("FAIL bad_mode_seq got v=%b r=%h t=%0d want v=1 r=0 t=21",
               out_valid, out_result, out_tag);
    else n_pass++;
    send(32'h1234_5678, 2'b11, 2'b00, 5'd22);
    n_checks++;
    if (out_result !== 32'h0 || out_tag !== 5'd22)
      $display("FAIL bad_mode_sub got r=%h t=%0d want r=0 t=22",
               out_result, out_tag);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int rcvd = 0;
    int last_k = -1;
    in_pack_mode = 2'b00;
    in_op = 2'b00;
    for (int k = 0; k < 30; k++) begin
      out_ready = !(k >= 2 && k <= 4);
      in_valid  = (sent < 8);
      in_tag    = sent[TAG_W-1:0];
      in_diff   = 32'(sent) + 32'h100;
      #3;
      if (k == 3) begin
        n_checks++;
        if (in_ready !== 1'b0)
          $display("FAIL b2b_in_ready_full got %b want 0", in_ready);
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if (in_ready !== 1'b1)
          $display("FAIL b2b_in_ready_drain got %b want 1", in_ready);
        else n_pass++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (out_tag !== rcvd[TAG_W-1:0] ||
            out_result !== 32'(rcvd) + 32'h100)
          $display("FAIL b2b_order got t=%0d r=%h want t=%0d r=%h",
                   out_tag, out_result, rcvd, 32'(rcvd) + 32'h100);
        else n_pass++;
        rcvd++;
        last_k = k;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    n_checks++;
    if (rcvd != 8)
      $display("FAIL b2b_count got %0d want 8", rcvd);
    else n_pass++;
    n_checks++;
    if (last_k != 11)
      $display("FAIL b2b_throughput last cycle got %0d want 11", last_k);
    else n_pass++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    send(32'h1, 2'b00, 2'b00, 5'd10);
    send(32'h2, 2'b00, 2'b00, 5'd11);
    n_checks++;
    if (in_ready !== 1'b0 || out_tag !== 5'd10)
      $display("FAIL flush_setup got rdy=%b t=%0d want rdy=0 t=10",
               in_ready, out_tag);
    else n_pass++;
    in_valid = 1'b1; in_tag = 5'd12; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_full got v=%b rdy=%b want v=0 rdy=1",
               out_valid, in_ready);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_no_ghost got v=%b t=%0d want v=0",
                 out_valid, out_tag);
      else n_pass++;
    end
    out_ready = 1'b0;
    send(32'h3, 2'b00, 2'b00, 5'd13);
    in_valid = 1'b1; in_tag = 5'd14; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_accepting got v=%b rdy=%b want v=0 rdy=1",
               out_valid, in_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL flush_drop_input got v=%b t=%0d want v=0",
               out_valid, out_tag);
    else n_pass++;
    send(32'h6, 2'b00, 2'b00, 5'd15);
    n_checks++;
    if (out_valid !== 1'b1 || out_tag !== 5'd15 || out_result !== 32'h6)
      $display("FAIL flush_recover got v=%b t=%0d r=%h want v=1 t=15 r=6",
               out_valid, out_tag, out_result);
    else n_pass++;
    tick();
  endtask

`ifdef SUB_CMP_STAGE_PERF_EN
  task automatic test_perf;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (perf_xfer_cnt !== '0 || perf_stall_cnt !== '0)
      $display("FAIL perf_reset got x=%0d s=%0d want 0 0",
               perf_xfer_cnt, perf_stall_cnt);
    else n_pass++;
    out_ready = 1'b0;
    send(32'h0, 2'b00, 2'b00, 5'd0);
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    for (int t = 1; t <= 4; t++) send(32'(t), 2'b00, 2'b00, 5'(t));
    tick();
    tick();
    n_checks++;
    if (perf_xfer_cnt !== 32'd5 || perf_stall_cnt !== 32'd4)
      $display("FAIL perf_counts got x=%0d s=%0d want 5 4",
               perf_xfer_cnt, perf_stall_cnt);
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++;
    if (perf_xfer_cnt !== 32'd5 || perf_stall_cnt !== 32'd4)
      $display("FAIL perf_flush got x=%0d s=%0d want 5 4",
               perf_xfer_cnt, perf_stall_cnt);
    else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (perf_xfer_cnt !== '0 || perf_stall_cnt !== '0)
      $display("FAIL perf_clear got x=%0d s=%0d want 0 0",
               perf_xfer_cnt, perf_stall_cnt);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_diff = '0; in_pack_mode = '0; in_op = '0; in_tag = '0;
    #1;
    test_reset();
    test_sub_word();
    test_masks();
    test_invalid_mode();
    test_back_to_back();
    test_flush();
`ifdef SUB_CMP_STAGE_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
